// File: rtl/pcs_scrambler.sv
// 64b/66b TX scrambler, x^58 + x^39 + 1 self-synchronous, with bypass, seed reload
// and a saturating invalid-sync-header counter. Sync header passes through unscrambled.
module pcs_scrambler #(
    parameter int          WIDTH = 64,
    parameter logic [57:0] SEED  = 58'h3FF_FFFF_FFFF_FFFF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_csr_pcs_scramb_dis,
    input  logic             i_csr_seed_load,
    input  logic             i_csr_err_clr,
    input  logic [WIDTH-1:0] i_din,
    input  logic [1:0]       i_din_sh,
    input  logic             i_din_en,
    output logic             o_din_rdy,
    output logic [WIDTH-1:0] o_dout,
    output logic [1:0]       o_dout_sh,
    output logic             o_dout_en,
    input  logic             i_dout_rdy,
    output logic [15:0]      o_err_cnt
);

    typedef enum logic {
        ST_SEED = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    logic [57:0]      r_s;
    logic             r_dis_meta;
    logic             r_dis_sync;
    logic [WIDTH-1:0] r_dout;
    logic [1:0]       r_dout_sh;
    logic             r_dout_en;
    logic [15:0]      r_err_cnt;

    logic             w_accept;
    logic             w_take;
    logic             w_sh_bad;
    logic [WIDTH-1:0] w_scr;

    assign o_din_rdy = (r_state == ST_RUN) && (!r_dout_en || i_dout_rdy);
    assign w_accept  = i_din_en && o_din_rdy;
    assign w_take    = r_dout_en && i_dout_rdy;
    assign w_sh_bad  = (i_din_sh == 2'b00) || (i_din_sh == 2'b11);

    // History h = {out, s}: bits >= 39 feed back on freshly scrambled bits of this block.
    always_comb begin : p_scramble
        logic [WIDTH+57:0] w_h;
        w_h = {{WIDTH{1'b0}}, r_s};
        for (int i = 0; i < WIDTH; i++) begin
            w_h[58+i] = i_din[i] ^ w_h[i+19] ^ w_h[i];
        end
        w_scr = w_h[WIDTH+57:58];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dis_meta <= 1'b0;
            r_dis_sync <= 1'b0;
        end else begin
            r_dis_meta <= i_csr_pcs_scramb_dis;
            r_dis_sync <= r_dis_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_SEED;
            r_s       <= SEED;
            r_dout    <= '0;
            r_dout_sh <= 2'b00;
            r_dout_en <= 1'b0;
            r_err_cnt <= 16'h0000;
        end else begin
            case (r_state)
                ST_SEED: begin
                    r_s     <= SEED;
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_accept && !r_dis_sync) begin
                        r_s <= w_scr[WIDTH-1:WIDTH-58];
                    end
                    if (i_csr_seed_load) begin
                        r_state <= ST_SEED;
                    end
                end
                default: r_state <= ST_SEED;
            endcase

            if (w_accept) begin
                r_dout    <= r_dis_sync ? i_din : w_scr;
                r_dout_sh <= i_din_sh;
                r_dout_en <= 1'b1;
            end else if (w_take) begin
                r_dout_en <= 1'b0;
            end

            // Clear wins over a same-cycle increment.
            if (i_csr_err_clr) begin
                r_err_cnt <= 16'h0000;
            end else if (w_accept && w_sh_bad && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'h0001;
            end
        end
    end

    assign o_dout    = r_dout;
    assign o_dout_sh = r_dout_sh;
    assign o_dout_en = r_dout_en;
    assign o_err_cnt = r_err_cnt;

endmodule
